addr_freelist_mgr_v0_3: RTL and testbench
=========================================

// Module: addr_freelist_mgr_v0_3
// PURPOSE
// Parametrised successor free-list address manager for the packet buffer: hands out free buffer
// word addresses (alloc) and takes back released addresses (free) through a singly linked free list.
// The link table is a flip-flop array initialised by reset, so no COE-loaded block RAM is needed.
// Adds: arbitrary DEPTH, valid/en alloc handshake, explicit free address input, simultaneous
// alloc+free at every occupancy, sticky over/underflow errors, and a peak-occupancy watermark.
// PARAMETERS
// ADDR_WIDTH            6    width of a buffer address; 2**ADDR_WIDTH >= DEPTH
// DEPTH                 64   number of managed addresses (0..DEPTH-1); DEPTH >= 2
// THRESHOLD_ALMOST_FULL 8    almost_full when used count >= DEPTH-THRESHOLD_ALMOST_FULL
// PORTS
// clk                  in   1             clock; all state on rising edge
// rstn                 in   1             asynchronous active-low reset
// m_axis_alloc_addr    out  ADDR_WIDTH    current free-list head (address offered for allocation)
// m_axis_alloc_valid   out  1             1 when at least one free address exists
// s_axis_alloc_en      in   1             consume m_axis_alloc_addr this cycle
// s_axis_free_en       in   1             return s_axis_free_addr to the free list this cycle
// s_axis_free_addr     in   ADDR_WIDTH    address being released
// s_axis_clr_stats     in   1             clear error flags and watermark (sync, 1 cycle)
// m_axis_used_count    out  ADDR_WIDTH+1  addresses currently allocated, 0..DEPTH
// m_axis_free_count    out  ADDR_WIDTH+1  DEPTH - used_count
// m_axis_almost_full   out  1             used_count >= DEPTH-THRESHOLD_ALMOST_FULL
// m_axis_is_empty      out  1             used_count == 0 (nothing allocated)
// m_axis_peak_used     out  ADDR_WIDTH+1  max used_count since reset/clear
// m_axis_err_underflow out  1             sticky: alloc_en while alloc_valid==0
// m_axis_err_overflow  out  1             sticky: free_en while used_count==0
// BEHAVIOUR
// - Reset (async assert, sync release): head=0, tail=DEPTH-1, link[i]=i+1 for i<DEPTH-1,
//   link[DEPTH-1]=0, used=0, peak=0, errors=0 -> alloc_addr=0, alloc_valid=1, is_empty=1,
//   almost_full=0, free_count=DEPTH. Reset mid-operation discards all allocations.
// - Outputs are registered-state derived (combinational from regs only); zero input->output paths.
// - alloc accepted = s_axis_alloc_en & alloc_valid; free accepted = s_axis_free_en & (used!=0).
// - Alloc only: head <= link[head]; used+1. Address presented is usable the same cycle.
// - Free only: link[tail] <= free_addr; tail <= free_addr; used-1.
//   If free list empty (used==DEPTH): head <= free_addr, tail <= free_addr; link write skipped.
// - Alloc+free same cycle: used unchanged. If free count==1 (head==tail): head<=free_addr,
//   tail<=free_addr. Else head<=link[head], link[tail]<=free_addr, tail<=free_addr.
//   If used==DEPTH alloc is refused (valid=0): treated as free only, err_underflow set.
// - Rejected ops change no list state; they set the sticky error. Out-of-range free_addr
//   (>=DEPTH) is also rejected and sets err_overflow.
// - No double-free detection; caller guarantees each freed address is currently allocated.
// - peak <= max(peak, next used) every cycle. clr_stats: errors<=0, peak<=current used; a
//   simultaneous error event in the same cycle wins (flag stays 1).
// - used_count arithmetic in ADDR_WIDTH+1 bits; never wraps (guarded by accept conditions).
// TESTING (DEPTH=8, THRESHOLD=2, ADDR_WIDTH=3)
// 1 reset, 8 back-to-back allocs -> addrs 0..7 in order; after 8th alloc_valid=0, used=8, almost_full=1 from used=6.
// 2 from full: free 5, free 2, then 2 allocs -> alloc_addr 5 then 2; free_count 2->0.
// 3 used=7 (one free, head==tail=7): alloc+free(3) same cycle -> next alloc_addr=3, used=7.
// 4 used=8: alloc_en+free_en(4) -> err_underflow=1, used=7, alloc_addr=4.
// 5 used=0: free_en(1) -> err_overflow=1, state unchanged; clr_stats -> both errors 0, peak=0.
// 6 alloc 3 addrs then assert rstn=0 mid-cycle -> outputs at reset values immediately, alloc_addr=0.

Source files
------------

// File: rtl/addr_freelist_mgr_v0_3.sv
// addr_freelist_mgr_v0_3
// Free-list address manager for the packet buffer. Free addresses are kept as a
// singly linked list (head -> link[head] -> ... -> tail). Allocation pops the head
// and release appends at the tail. The link table is a register array, so reset
// restores the full 0..DEPTH-1 chain without any preloaded memory.
// Also tracks occupancy, a peak-occupancy watermark and sticky misuse flags.
module addr_freelist_mgr_v0_3 #(
  parameter int ADDR_WIDTH            = 6,
  parameter int DEPTH                 = 64,
  parameter int THRESHOLD_ALMOST_FULL = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  output logic [ADDR_WIDTH-1:0] m_axis_alloc_addr,
  output logic                  m_axis_alloc_valid,
  input  logic                  s_axis_alloc_en,
  input  logic                  s_axis_free_en,
  input  logic [ADDR_WIDTH-1:0] s_axis_free_addr,
  input  logic                  s_axis_clr_stats,
  output logic [ADDR_WIDTH:0]   m_axis_used_count,
  output logic [ADDR_WIDTH:0]   m_axis_free_count,
  output logic                  m_axis_almost_full,
  output logic                  m_axis_is_empty,
  output logic [ADDR_WIDTH:0]   m_axis_peak_used,
  output logic                  m_axis_err_underflow,
  output logic                  m_axis_err_overflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C    = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_C      = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] AF_LEVEL_C = (ADDR_WIDTH+1)'(DEPTH - THRESHOLD_ALMOST_FULL);

  logic [ADDR_WIDTH-1:0] link_q [DEPTH];
  logic [ADDR_WIDTH-1:0] head_q, head_d;
  logic [ADDR_WIDTH-1:0] tail_q, tail_d;
  logic [ADDR_WIDTH:0]   used_q, used_d;
  logic [ADDR_WIDTH:0]   peak_q, peak_d;
  logic                  err_uf_q, err_uf_d;
  logic                  err_of_q, err_of_d;

  logic                  alloc_valid;
  logic                  alloc_ok;
  logic                  free_ok;
  logic                  free_in_range;
  logic                  uf_event;
  logic                  of_event;
  logic                  link_we;

  // A free address exists whenever not every address is allocated.
  assign alloc_valid   = (used_q != DEPTH_C);
  assign free_in_range = ({1'b0, s_axis_free_addr} < DEPTH_C);
  assign alloc_ok      = s_axis_alloc_en & alloc_valid;
  assign free_ok       = s_axis_free_en & (used_q != '0) & free_in_range;
  assign uf_event      = s_axis_alloc_en & ~alloc_valid;
  assign of_event      = s_axis_free_en & ((used_q == '0) | ~free_in_range);

  // Next-state for list pointers, occupancy, watermark and sticky errors.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    used_d  = used_q;
    link_we = 1'b0;
    unique case ({alloc_ok, free_ok})
      2'b10: begin
        head_d = link_q[head_q];
        used_d = used_q + ONE_C;
      end
      2'b01: begin
        tail_d = s_axis_free_addr;
        used_d = used_q - ONE_C;
        // An empty free list has no tail entry to link from: the returned address becomes the whole list.
        if (used_q == DEPTH_C) head_d = s_axis_free_addr;
        else                   link_we = 1'b1;
      end
      2'b11: begin
        tail_d = s_axis_free_addr;
        // With a single free entry, the head being popped is also the tail being linked from.
        if (used_q == DEPTH_C - ONE_C) begin
          head_d = s_axis_free_addr;
        end else begin
          head_d  = link_q[head_q];
          link_we = 1'b1;
        end
      end
      default: ;
    endcase

    if (s_axis_clr_stats) peak_d = used_d;
    else                  peak_d = (used_d > peak_q) ? used_d : peak_q;

    // An error seen in the same cycle as a clear still leaves the flag set.
    err_uf_d = (err_uf_q & ~s_axis_clr_stats) | uf_event;
    err_of_d = (err_of_q & ~s_axis_clr_stats) | of_event;
  end

  // Pointer, counter and flag registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q   <= '0;
      tail_q   <= ADDR_WIDTH'(DEPTH - 1);
      used_q   <= '0;
      peak_q   <= '0;
      err_uf_q <= 1'b0;
      err_of_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      used_q   <= used_d;
      peak_q   <= peak_d;
      err_uf_q <= err_uf_d;
      err_of_q <= err_of_d;
    end
  end

  // Link table: each entry resets to the next address (last wraps to 0) and is rewritten when it is the tail.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_link
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        link_q[gi] <= (gi == DEPTH - 1) ? '0 : ADDR_WIDTH'(gi + 1);
      end else if (link_we && (tail_q == ADDR_WIDTH'(gi))) begin
        link_q[gi] <= s_axis_free_addr;
      end
    end
  end

  assign m_axis_alloc_addr    = head_q;
  assign m_axis_alloc_valid   = alloc_valid;
  assign m_axis_used_count    = used_q;
  assign m_axis_free_count    = DEPTH_C - used_q;
  assign m_axis_almost_full   = (used_q >= AF_LEVEL_C);
  assign m_axis_is_empty      = (used_q == '0);
  assign m_axis_peak_used     = peak_q;
  assign m_axis_err_underflow = err_uf_q;
  assign m_axis_err_overflow  = err_of_q;

endmodule

// File: tb/tb_addr_freelist_mgr_v0_3.sv
// Bench for addr_freelist_mgr_v0_3 (DEPTH=8, THRESHOLD=2, ADDR_WIDTH=3).
// Reference: the free list is a FIFO of addresses (pop front on alloc, push back on free),
// plus a list of currently allocated addresses used to pick legal frees.
module tb_addr_freelist_mgr_v0_3;
  localparam int AW  = 3;
  localparam int DEP = 8;
  localparam int THR = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic [AW-1:0] alloc_addr;
  logic          alloc_valid;
  logic          alloc_en;
  logic          free_en;
  logic [AW-1:0] free_addr;
  logic          clr_stats;
  logic [AW:0]   used_count;
  logic [AW:0]   free_count;
  logic          almost_full;
  logic          is_empty;
  logic [AW:0]   peak_used;
  logic          err_uf;
  logic          err_of;

  addr_freelist_mgr_v0_3 #(.ADDR_WIDTH(AW), .DEPTH(DEP), .THRESHOLD_ALMOST_FULL(THR)) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .m_axis_alloc_addr   (alloc_addr),
    .m_axis_alloc_valid  (alloc_valid),
    .s_axis_alloc_en     (alloc_en),
    .s_axis_free_en      (free_en),
    .s_axis_free_addr    (free_addr),
    .s_axis_clr_stats    (clr_stats),
    .m_axis_used_count   (used_count),
    .m_axis_free_count   (free_count),
    .m_axis_almost_full  (almost_full),
    .m_axis_is_empty     (is_empty),
    .m_axis_peak_used    (peak_used),
    .m_axis_err_underflow(err_uf),
    .m_axis_err_overflow (err_of)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  int fifo_q[$];
  int alloc_list[$];
  int m_peak;
  bit m_uf;
  bit m_of;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fifo_q.delete();
    alloc_list.delete();
    for (int i = 0; i < DEP; i++) fifo_q.push_back(i);
    m_peak = 0;
    m_uf   = 1'b0;
    m_of   = 1'b0;
  endtask

  function automatic int m_used();
    return DEP - fifo_q.size();
  endfunction

  task automatic check_all(input string tag);
    int u;
    u = m_used();
    check({tag, ".valid"}, alloc_valid, (fifo_q.size() > 0));
    if (fifo_q.size() > 0) check({tag, ".addr"}, alloc_addr, fifo_q[0]);
    check({tag, ".used"}, used_count, u);
    check({tag, ".free"}, free_count, DEP - u);
    check({tag, ".afull"}, almost_full, (u >= DEP - THR));
    check({tag, ".empty"}, is_empty, (u == 0));
    check({tag, ".peak"}, peak_used, m_peak);
    check({tag, ".uf"}, err_uf, m_uf);
    check({tag, ".of"}, err_of, m_of);
  endtask

  // One clock of stimulus, reference update, then sample 1ns after the edge.
  task automatic step(input bit a, input bit f, input int fa, input bit c, input string tag);
    bit a_ok, f_ok, uf_ev, of_ev;
    int u;
    @(negedge clk);
    alloc_en  = a;
    free_en   = f;
    free_addr = AW'(fa);
    clr_stats = c;
    u     = m_used();
    a_ok  = a && (fifo_q.size() > 0);
    f_ok  = f && (u > 0) && (fa < DEP);
    uf_ev = a && !(fifo_q.size() > 0);
    of_ev = f && !((u > 0) && (fa < DEP));
    if (a_ok) alloc_list.push_back(fifo_q.pop_front());
    if (f_ok) begin
      fifo_q.push_back(fa);
      for (int i = 0; i < alloc_list.size(); i++)
        if (alloc_list[i] == fa) begin
          alloc_list.delete(i);
          break;
        end
    end
    u = m_used();
    if (c) begin
      m_peak = u;
      m_uf   = uf_ev;
      m_of   = of_ev;
    end else begin
      if (u > m_peak) m_peak = u;
      m_uf = m_uf | uf_ev;
      m_of = m_of | of_ev;
    end
    @(posedge clk);
    #1;
    $display("%s a=%0b f=%0b fa=%0d clr=%0b -> addr=%0d v=%0b used=%0d peak=%0d uf=%0b of=%0b",
             tag, a, f, fa, c, alloc_addr, alloc_valid, used_count, peak_used, err_uf, err_of);
    check_all(tag);
  endtask

  initial begin
    int fa;
    bit a, f, c;
    rstn = 1'b0; alloc_en = 0; free_en = 0; free_addr = '0; clr_stats = 0;
    model_reset();
    #12;
    check_all("reset");
    check("reset.addr0", alloc_addr, 0);
    @(negedge clk);
    rstn = 1'b1;

    // 1: drain all eight addresses in order
    for (int i = 0; i < DEP; i++) step(1, 0, 0, 0, $sformatf("t1.alloc%0d", i));
    check("t1.full_valid", alloc_valid, 0);

    // 2: release 5 and 2, they come back in release order
    step(0, 1, 5, 0, "t2.free5");
    step(0, 1, 2, 0, "t2.free2");
    check("t2.head5", alloc_addr, 5);
    step(1, 0, 0, 0, "t2.alloc5");
    check("t2.head2", alloc_addr, 2);
    step(1, 0, 0, 0, "t2.alloc2");
    check("t2.free0", free_count, 0);

    // 3: single free entry, simultaneous alloc and free
    step(0, 1, 7, 0, "t3.free7");
    step(1, 1, 3, 0, "t3.both");
    check("t3.head3", alloc_addr, 3);

    // 4: full list, alloc refused while free accepted
    step(1, 0, 0, 0, "t4.alloc");
    step(1, 1, 4, 0, "t4.both");
    check("t4.uf", err_uf, 1);
    check("t4.head4", alloc_addr, 4);

    // 5: release everything, then free into an empty allocation set
    while (alloc_list.size() > 0) step(0, 1, alloc_list[0], 0, "t5.drain");
    step(0, 1, 1, 0, "t5.badfree");
    check("t5.of", err_of, 1);
    step(0, 0, 0, 1, "t5.clr");
    check("t5.peak0", peak_used, 0);

    // Randomized traffic, only legal frees except when nothing is allocated
    for (int n = 0; n < 400; n++) begin
      a = ($urandom_range(0, 99) < 55);
      f = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 29) == 0);
      if (alloc_list.size() > 0) fa = alloc_list[$urandom_range(0, alloc_list.size() - 1)];
      else                       fa = $urandom_range(0, DEP - 1);
      step(a, f, fa, c, $sformatf("rnd%0d", n));
    end

    // 6: reset asserted mid-cycle with allocations outstanding
    step(0, 0, 0, 1, "t6.clr");
    @(negedge clk);
    rstn = 1'b0;
    model_reset();
    #1;
    check_all("t6.pre_rst");
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, $sformatf("t6.alloc%0d", i));
    @(negedge clk);
    alloc_en = 0;
    @(posedge clk);
    #3;
    rstn = 1'b0;
    model_reset();
    #1;
    $display("t6.async_rst -> addr=%0d v=%0b used=%0d", alloc_addr, alloc_valid, used_count);
    check_all("t6.rst");
    check("t6.addr0", alloc_addr, 0);
    check("t6.freecnt", free_count, DEP);
    #10;
    rstn = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
